// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester line arbiter in front of main memory.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        HOLD
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin select: on a tie, pick the requester that was not served last.
module rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       pick_o
);

    assign valid_o = |req_i;
    assign pick_o  = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/mem_arbiter.sv
// Line-level arbiter sharing main memory between I-cache (0) and D-cache (1).
// IDLE: arbitrate | BUSY: memory transaction for owner | HOLD: post-write slot for an atomic refill
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int LINE_ADDR_LEN = 3,
    parameter  int ADDR_LEN      = 9,
    localparam int LINE_SIZE     = 2 ** LINE_ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        c_rd_req,
    input  logic [NUM_REQ-1:0]        c_wr_req,
    input  logic [ADDR_LEN-1:0]       c_addr    [NUM_REQ],
    input  logic [LINE_SIZE-1:0][31:0] c_wr_line [NUM_REQ],
    output logic [NUM_REQ-1:0]        c_gnt,
    output logic [LINE_SIZE-1:0][31:0] c_rd_line,
    output logic                      mem_rd_req,
    output logic                      mem_wr_req,
    output logic [ADDR_LEN-1:0]       mem_addr,
    output logic [LINE_SIZE-1:0][31:0] mem_wr_line,
    input  logic                      mem_gnt,
    input  logic [LINE_SIZE-1:0][31:0] mem_rd_line,
    output logic [31:0]               grant_cnt [NUM_REQ]
);

    state_e                     state_q, state_d;
    op_e                        op_q, op_d;
    logic                       owner_q, owner_d;
    logic                       last_q, last_d;
    logic [NUM_REQ-1:0][31:0]   cnt_q, cnt_d;
    logic                       pick_valid;
    logic                       pick;

    rr_pick u_rr_pick (
        .req_i   (c_rd_req | c_wr_req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .pick_o  (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        c_rd_line   = '0;
        c_gnt       = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick;
                    op_d    = c_wr_req[pick] ? OP_WR : OP_RD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_rd_req     = (op_q == OP_RD);
                mem_wr_req     = (op_q == OP_WR);
                mem_addr       = c_addr[owner_q];
                mem_wr_line    = c_wr_line[owner_q];
                c_rd_line      = mem_rd_line;
                c_gnt[owner_q] = mem_gnt;
                // main_mem cannot abort, so only mem_gnt ends the transaction
                if (mem_gnt) begin
                    if (op_q == OP_WR) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            HOLD: begin
                if (c_rd_req[owner_q]) begin
                    op_d    = OP_RD;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (c_gnt[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g] = cnt_q[g];
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a schedule model.
module tb_mem_arbiter;

    logic                clk;
    logic                rst;
    logic [1:0]          c_rd_req;
    logic [1:0]          c_wr_req;
    logic [8:0]          c_addr    [2];
    logic [7:0][31:0]    c_wr_line [2];
    logic [1:0]          c_gnt;
    logic [7:0][31:0]    c_rd_line;
    logic                mem_rd_req;
    logic                mem_wr_req;
    logic [8:0]          mem_addr;
    logic [7:0][31:0]    mem_wr_line;
    logic                mem_gnt;
    logic [7:0][31:0]    mem_rd_line;
    logic [31:0]         grant_cnt [2];

    mem_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .c_rd_req    (c_rd_req),
        .c_wr_req    (c_wr_req),
        .c_addr      (c_addr),
        .c_wr_line   (c_wr_line),
        .c_gnt       (c_gnt),
        .c_rd_line   (c_rd_line),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_gnt     (mem_gnt),
        .mem_rd_line (mem_rd_line),
        .grant_cnt   (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Schedule model: cycle numbers at which the arbiter looks at requests and serves them.
    int          cyc = 0;
    int          m_free = 0;
    int          m_start = 0;
    int          m_hold_at = -1;
    int          m_own = 0;
    int          m_last = 1;
    bit          m_txn = 0;
    bit          m_wr = 0;
    logic [31:0] exp_cnt [2];
    logic [1:0]  gnt_seen;
    int          gnt_log [$];
    int          gnt_lat = 1;
    int          wcnt = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0][31:0] rand_line();
        logic [7:0][31:0] l;
        for (int k = 0; k < 8; k++) l[k] = $urandom;
        return l;
    endfunction

    function automatic int log_code();
        int code = 0;
        foreach (gnt_log[k]) code = code * 4 + gnt_log[k] + 1;
        return code;
    endfunction

    task automatic model_step();
        logic       exp_act;
        logic [1:0] exp_gnt;
        logic [1:0] req;
        gnt_seen = c_gnt;
        if (c_gnt != 2'b00) gnt_log.push_back(c_gnt == 2'b11 ? 3 : (c_gnt[1] ? 1 : 0));
        if (rst) begin
            m_txn      = 0;
            m_hold_at  = -1;
            m_free     = cyc + 1;
            m_last     = 1;
            exp_cnt[0] = '0;
            exp_cnt[1] = '0;
            chk("rst_out", {c_gnt, mem_rd_req, mem_wr_req}, '0);
            chk("rst_cnt", {grant_cnt[1], grant_cnt[0]}, '0);
            cyc++;
            return;
        end
        exp_act = m_txn && (cyc >= m_start);
        exp_gnt = 2'b00;
        if (exp_act && mem_gnt) exp_gnt[m_own] = 1'b1;
        chk("req_gnt", {c_gnt, mem_rd_req, mem_wr_req}, {exp_gnt, exp_act && !m_wr, exp_act && m_wr});
        chk("mem_addr", mem_addr, exp_act ? c_addr[m_own] : 9'd0);
        chk("mem_wr_line", mem_wr_line, exp_act ? c_wr_line[m_own] : '0);
        chk("c_rd_line", c_rd_line, exp_act ? mem_rd_line : '0);
        chk("grant_cnt", {grant_cnt[1], grant_cnt[0]}, {exp_cnt[1], exp_cnt[0]});

        req = c_rd_req | c_wr_req;
        if (exp_act && mem_gnt) begin
            if (exp_cnt[m_own] != 32'hFFFF_FFFF) exp_cnt[m_own] = exp_cnt[m_own] + 32'd1;
            m_txn = 0;
            if (m_wr) begin
                m_hold_at = cyc + 1;
            end else begin
                m_last = m_own;
                m_free = cyc + 1;
            end
        end else if (m_hold_at == cyc) begin
            m_hold_at = -1;
            if (c_rd_req[m_own]) begin
                m_txn   = 1;
                m_wr    = 0;
                m_start = cyc + 1;
            end else begin
                m_last = m_own;
                m_free = cyc + 1;
            end
        end else if (!m_txn && m_hold_at < 0 && cyc == m_free) begin
            if (req != 2'b00) begin
                // a tie goes to whoever was not served most recently
                m_own   = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                m_wr    = c_wr_req[m_own];
                m_txn   = 1;
                m_start = cyc + 1;
            end else begin
                m_free = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic respond();
        if (rst) begin
            mem_gnt = 1'b0;
            wcnt    = 0;
        end else if (mem_rd_req || mem_wr_req) begin
            if (wcnt >= gnt_lat) begin
                mem_gnt     = 1'b1;
                mem_rd_line = rand_line();
                wcnt        = 0;
            end else begin
                mem_gnt = 1'b0;
                wcnt++;
            end
        end else begin
            mem_gnt = 1'b0;
            wcnt    = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic wait_gnt(input int i, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!gnt_seen[i] && n < 60);
        chk(tag, gnt_seen[i], 1'b1);
    endtask

    task automatic do_reset();
        c_rd_req = 2'b00;
        c_wr_req = 2'b00;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        gnt_log.delete();
    endtask

    task automatic new_req(input int i);
        int op;
        op = $urandom_range(0, 2);
        c_addr[i]    = 9'($urandom);
        c_wr_line[i] = rand_line();
        c_rd_req[i]  = (op != 1);
        c_wr_req[i]  = (op != 0);
    endtask

    task automatic rand_drive();
        for (int i = 0; i < 2; i++) begin
            if ((c_rd_req[i] | c_wr_req[i]) && gnt_seen[i]) begin
                if ($urandom_range(0, 1) == 1) new_req(i);
                else begin
                    c_rd_req[i] = 1'b0;
                    c_wr_req[i] = 1'b0;
                end
            end else if (!(c_rd_req[i] | c_wr_req[i])) begin
                if ($urandom_range(0, 2) == 0) new_req(i);
            end else if ($urandom_range(0, 59) == 0) begin
                c_rd_req[i] = 1'b0;
                c_wr_req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        int bad;
        rst         = 1'b1;
        c_rd_req    = 2'b00;
        c_wr_req    = 2'b00;
        c_addr[0]   = '0;
        c_addr[1]   = '0;
        c_wr_line[0] = '0;
        c_wr_line[1] = '0;
        mem_gnt     = 1'b0;
        mem_rd_line = '0;
        exp_cnt[0]  = '0;
        exp_cnt[1]  = '0;
        gnt_seen    = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        // single read with one-cycle request latency
        gnt_lat = 2;
        c_addr[0]   = 9'h012;
        c_rd_req[0] = 1'b1;
        chk("r030_lat0", mem_rd_req, 1'b0);
        tick();
        chk("r030_lat1", {mem_rd_req, mem_addr}, {1'b1, 9'h012});
        wait_gnt(0, "r030_gnt");
        c_rd_req[0] = 1'b0;
        chk("r030_cnt", grant_cnt[0], 32'd1);

        // tie straight after reset: requester 0 first
        do_reset();
        gnt_lat   = $urandom_range(0, 2);
        c_addr[0] = 9'h001;
        c_addr[1] = 9'h002;
        c_rd_req  = 2'b11;
        wait_gnt(0, "r031_g0");
        c_rd_req[0] = 1'b0;
        wait_gnt(1, "r031_g1");
        c_rd_req[1] = 1'b0;
        chk("r031_order", log_code(), 6);

        // continuous contention alternates
        do_reset();
        gnt_lat  = $urandom_range(0, 3);
        c_rd_req = 2'b11;
        for (int n = 0; n < 400 && gnt_log.size() < 20; n++) tick();
        c_rd_req = 2'b00;
        bad = 0;
        foreach (gnt_log[k]) if (gnt_log[k] != k % 2) bad++;
        chk("r033_alt", {gnt_log.size(), bad}, {32'd20, 32'd0});
        chk("r033_cnt", {grant_cnt[1], grant_cnt[0]}, {32'd10, 32'd10});

        // write-back then refill stays atomic against a waiting requester 0
        do_reset();
        gnt_lat      = 1;
        c_addr[1]    = 9'h0A5;
        c_wr_line[1] = rand_line();
        c_wr_req[1]  = 1'b1;
        tick();
        c_addr[0]   = 9'($urandom);
        c_rd_req[0] = 1'b1;
        wait_gnt(1, "r032_wr");
        c_wr_req[1] = 1'b0;
        c_rd_req[1] = 1'b1;
        wait_gnt(1, "r032_rd");
        c_rd_req[1] = 1'b0;
        wait_gnt(0, "r032_r0");
        c_rd_req[0] = 1'b0;
        chk("r032_order", log_code(), 41);

        // reset while a write is outstanding
        do_reset();
        gnt_lat     = 0;
        c_rd_req[0] = 1'b1;
        wait_gnt(0, "r034_pre");
        c_rd_req[0]  = 1'b0;
        gnt_lat      = 1000;
        c_wr_line[1] = rand_line();
        c_wr_req[1]  = 1'b1;
        tick();
        tick();
        chk("r034_busy", mem_wr_req, 1'b1);
        rst      = 1'b1;
        mem_gnt  = 1'b1;
        c_wr_req = 2'b00;
        #1;
        chk("r034_imm", {c_gnt, mem_rd_req, mem_wr_req}, '0);
        mem_gnt = 1'b0;
        tick();
        rst     = 1'b0;
        gnt_lat = 0;
        chk("r034_cnt", {grant_cnt[1], grant_cnt[0]}, '0);
        c_rd_req[1] = 1'b1;
        tick();
        chk("r034_idle", mem_rd_req, 1'b1);
        wait_gnt(1, "r034_post");
        c_rd_req[1] = 1'b0;

        // saturation of the grant counter
        do_reset();
        force dut.cnt_q = {32'd0, 32'hFFFF_FFFF};
        #1;
        release dut.cnt_q;
        exp_cnt[0]  = 32'hFFFF_FFFF;
        gnt_lat     = 0;
        c_addr[0]   = 9'($urandom);
        c_rd_req[0] = 1'b1;
        wait_gnt(0, "r035_gnt");
        c_rd_req[0] = 1'b0;
        chk("r035_sat", grant_cnt[0], 32'hFFFF_FFFF);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 16 == 0) gnt_lat = $urandom_range(0, 3);
            rand_drive();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
